// File: rtl/icache_responder.sv
// rtl/icache_responder.sv - direct-mapped 8-line instruction cache with block refill from instruction memory
module icache_responder (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [31:0]  PC,
    output logic [31:0]  INSTRUCTION,
    output logic         BUSYWAIT,
    output logic         MEM_READ,
    output logic [5:0]   MEM_ADDRESS,
    input  logic [127:0] MEM_READDATA,
    input  logic         MEM_BUSYWAIT
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_MEM_READ = 2'd1;
    localparam logic [1:0] S_UPDATE   = 2'd2;

    // Address fields; only PC[9:2] select anything, so the space wraps at 1 KiB.
    logic [2:0] pc_tag;
    logic [2:0] pc_index;
    logic [1:0] pc_word;
    logic       unused_pc;

    assign pc_tag    = PC[9:7];
    assign pc_index  = PC[6:4];
    assign pc_word   = PC[3:2];
    assign unused_pc = ^{PC[31:10], PC[1:0]};

    // Line storage
    logic [7:0]   valid_q;
    logic [2:0]   tag_q  [8];
    logic [127:0] data_q [8];

    // Fill control
    logic [1:0]   state_q, state_d;
    logic         first_q, first_d;
    logic [5:0]   fill_addr_q, fill_addr_d;
    logic [127:0] fill_buf_q, fill_buf_d;
    logic         line_we;
    logic         hit;
    logic [127:0] sel_line;

    assign hit      = valid_q[pc_index] && (tag_q[pc_index] == pc_tag);
    assign sel_line = data_q[pc_index];

    // The fill register doubles as the memory address so it holds between fills.
    assign MEM_ADDRESS = fill_addr_q;
    assign MEM_READ    = (state_q == S_MEM_READ);

    // Instruction is only presented on a hit while idle, zero otherwise.
    always_comb begin
        INSTRUCTION = 32'h0;
        if ((state_q == S_IDLE) && hit) begin
            INSTRUCTION = sel_line[{pc_word, 5'd0} +: 32];
        end
    end

    // Next-state logic: miss detect, memory handshake, line update.
    always_comb begin
        state_d     = state_q;
        first_d     = 1'b0;
        fill_addr_d = fill_addr_q;
        fill_buf_d  = fill_buf_q;
        line_we     = 1'b0;
        BUSYWAIT    = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (hit) begin
                    BUSYWAIT = 1'b0;
                end else begin
                    fill_addr_d = {pc_tag, pc_index};
                    first_d     = 1'b1;
                    state_d     = S_MEM_READ;
                end
            end
            S_MEM_READ: begin
                // A stale low MEM_BUSYWAIT from the previous request must not
                // complete this one, so the first cycle never completes.
                if (!first_q && !MEM_BUSYWAIT) begin
                    fill_buf_d = MEM_READDATA;
                    state_d    = S_UPDATE;
                end
            end
            S_UPDATE: begin
                line_we = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state and valid bits; reset aborts any fill and invalidates every line.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= S_IDLE;
            first_q     <= 1'b0;
            fill_addr_q <= 6'd0;
            fill_buf_q  <= 128'd0;
            valid_q     <= 8'd0;
        end else begin
            state_q     <= state_d;
            first_q     <= first_d;
            fill_addr_q <= fill_addr_d;
            fill_buf_q  <= fill_buf_d;
            if (line_we) begin
                valid_q[fill_addr_q[2:0]] <= 1'b1;
            end
        end
    end

    // Tag and data arrays; contents are qualified by valid_q so they need no reset.
    always_ff @(posedge CLK) begin
        if (line_we) begin
            tag_q[fill_addr_q[2:0]]  <= fill_addr_q[5:3];
            data_q[fill_addr_q[2:0]] <= fill_buf_q;
        end
    end

endmodule

// File: doc/icache_responder.md
# icache_responder

Direct-mapped instruction cache serving the CPU's fetch port. It takes the CPU's 32-bit PC and returns the 32-bit INSTRUCTION, asserting BUSYWAIT to stall the CPU on a miss. On a miss it fetches a 128-bit block from the instruction memory over a read/busywait handshake. It sits between the CPU's PC output and the instruction memory.

## Interface
Parameters:
- none. Geometry is fixed: 8 lines × 16 bytes (4 words), 1024-byte instruction space.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- PC  in  32  fetch byte address from the CPU.
- INSTRUCTION  out  32  fetched instruction word.
- BUSYWAIT  out  1  high = INSTRUCTION not valid; the CPU must stall and hold PC.
- MEM_READ  out  1  block read request to instruction memory.
- MEM_ADDRESS  out  6  block address {tag, index}.
- MEM_READDATA  in  128  block returned by memory; word 0 in [31:0], word 3 in [127:96].
- MEM_BUSYWAIT  in  1  memory busy; read completes when it is low.

## Operation
- Address split, using PC[9:0] only:
  - tag = PC[9:7], index = PC[6:4], word = PC[3:2].
  - PC[1:0] and PC[31:10] are ignored, so addresses wrap modulo 1024.
- Per-line storage: valid bit, 3-bit tag, 128-bit data.
- hit = valid[index] && tag[index] == tag, evaluated combinationally.
- INSTRUCTION is the selected word of line[index] when hit && state == IDLE; otherwise 32'h0.
- FSM states:
  - IDLE
    - Hit: BUSYWAIT = 0, stay in IDLE.
    - Miss: BUSYWAIT = 1 in the same cycle. Latch block address {tag, index} into a fill register and go to MEM_READ on the next edge.
  - MEM_READ
    - MEM_READ = 1, MEM_ADDRESS = fill register, BUSYWAIT = 1.
    - MEM_BUSYWAIT is ignored in the first cycle of this state.
    - From the second cycle on, an edge with MEM_BUSYWAIT = 0 captures MEM_READDATA into a fill buffer and goes to UPDATE.
  - UPDATE
    - MEM_READ = 0, BUSYWAIT = 1.
    - At the next edge: write the fill buffer into line[fill index], set tag[fill index] = fill tag, set valid = 1, then go to IDLE.
- After UPDATE, IDLE re-evaluates hit with the current PC. If PC is unchanged this is a hit and BUSYWAIT falls.
- If PC changed during the fill (protocol violation):
  - the fill still completes for the latched address;
  - IDLE then treats the new PC as a fresh lookup.
- MEM_ADDRESS holds its last value outside MEM_READ.
- The cache is read-only. The CPU never writes through this block.

## Timing
- Reset (RESET = 0, asynchronous, effective immediately, no clock needed):
  - state = IDLE, all valid bits = 0, MEM_READ = 0, MEM_ADDRESS = 0, fill register and fill buffer = 0.
  - BUSYWAIT and INSTRUCTION follow the IDLE rules: after reset every lookup misses, so BUSYWAIT = 1 and INSTRUCTION = 0 while PC is applied.
- Reset asserted mid-fill (MEM_READ or UPDATE):
  - the fill is aborted and MEM_READ drops immediately;
  - no line is written and all lines are invalidated.
- Hit latency: 0 cycles. INSTRUCTION is valid in the same cycle PC is stable, with BUSYWAIT low.
- Miss timing, where N = number of MEM_READ cycles (≥ 2):
  - cycle 0: IDLE miss detect;
  - cycles 1..N: MEM_READ; memory completes at the edge ending cycle N;
  - cycle N+1: UPDATE;
  - cycle N+2: IDLE hit with BUSYWAIT = 0.
  - Total stall is N+2 cycles.
- A miss immediately after a fill goes straight back to MEM_READ, with no idle bubble beyond the detect cycle.
- A conflict miss (same index, different tag) overwrites the line; there is no write-back.

## Test plan
- Cold miss at PC = 0x000, memory returns words {0x0A, 0x0B, 0x0C, 0x0D} after 4 busy cycles:
  - MEM_READ high with MEM_ADDRESS = 6'd0;
  - BUSYWAIT high for 7 cycles;
  - then INSTRUCTION = 0x0000000A with BUSYWAIT low.
- After that fill, PC = 0x004, 0x008, 0x00C:
  - each is a same-cycle hit returning 0x0B, 0x0C, 0x0D;
  - MEM_READ stays 0.
- Conflict miss at PC = 0x080 (index 0, tag 1):
  - MEM_ADDRESS = 6'd8 and the line is refilled;
  - a subsequent PC = 0x000 misses again.
- PC = 0x400 after filling 0x000:
  - aliases to 0x000 and hits with no memory read.
- RESET pulled low in the 2nd MEM_READ cycle, then released:
  - MEM_READ drops at once;
  - PC = 0x000 misses and a new request is issued.
- MEM_BUSYWAIT held low from the start:
  - completion is not taken in the first MEM_READ cycle;
  - the fill finishes after exactly 2 MEM_READ cycles, for a 4-cycle stall.
